// File: rtl/window_writeback_if.sv
// Write port from the block writeback toward the activation buffer:
// a single valid/ready word-write channel.
interface window_writeback_if #(
  parameter int ADDR_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/window_writeback.sv
// Gathers a 4x4 int8 result block row by row, then writes it to the activation
// buffer as four packed 32-bit words in row order 0..3.
module window_writeback #(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   row_stride,
  input  logic signed [7:0]   C0 [0:3],
  input  logic signed [7:0]   C1 [0:3],
  input  logic signed [7:0]   C2 [0:3],
  input  logic signed [7:0]   C3 [0:3],
  input  logic                valid_C0,
  input  logic                valid_C1,
  input  logic                valid_C2,
  input  logic                valid_C3,
  window_writeback_if.master  wr,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Element 0 sits in the most significant byte of the packed word.
  typedef logic [0:3][7:0] row_t;

  function automatic logic [31:0] pack_row(input row_t row);
    return {row[0], row[1], row[2], row[3]};
  endfunction

  state_t            state_r;
  logic [3:0]        mask_r;
  logic [1:0]        row_idx_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] stride_r;
  row_t              buf_r       [0:3];

  logic [3:0]        valid_s;
  logic [3:0]        capture_s;
  logic [3:0]        mask_next_s;
  logic              accept_start_s;
  row_t              row_in_s    [0:3];
  row_t              buf_next_s  [0:3];

  // Row capture: buffer contents and mask as they will be after this edge.
  always_comb begin
    valid_s = {valid_C3, valid_C2, valid_C1, valid_C0};
    for (int e = 0; e < 4; e++) begin
      row_in_s[0][e] = C0[e];
      row_in_s[1][e] = C1[e];
      row_in_s[2][e] = C2[e];
      row_in_s[3][e] = C3[e];
    end
    accept_start_s = start && (state_r != ST_WRITE);
    capture_s      = ((state_r == ST_COLLECT) && !start) ? valid_s : 4'b0000;
    mask_next_s    = mask_r | capture_s;
    for (int r = 0; r < 4; r++) begin
      buf_next_s[r] = capture_s[r] ? row_in_s[r] : buf_r[r];
    end
  end

  // Control FSM with all write-port and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mask_r      <= 4'b0000;
      row_idx_r   <= 2'd0;
      base_r      <= {ADDR_W{1'b0}};
      stride_r    <= {ADDR_W{1'b0}};
      for (int r = 0; r < 4; r++) begin
        buf_r[r] <= 32'h0000_0000;
      end
      wr.wr_en    <= 1'b0;
      wr.wr_addr  <= {ADDR_W{1'b0}};
      wr.wr_data  <= 32'h0000_0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      buf_r <= buf_next_s;
      done  <= 1'b0;
      if (accept_start_s) begin
        // Restart from IDLE, COLLECT or DONE; pulses on this edge are dropped.
        state_r  <= ST_COLLECT;
        base_r   <= base_addr;
        stride_r <= row_stride;
        mask_r   <= 4'b0000;
        overflow <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (|valid_s) begin
              overflow <= 1'b1;
            end
          end
          ST_COLLECT: begin
            mask_r <= mask_next_s;
            if (mask_next_s == 4'b1111) begin
              state_r    <= ST_WRITE;
              row_idx_r  <= 2'd0;
              wr.wr_en   <= 1'b1;
              wr.wr_addr <= base_r;
              wr.wr_data <= pack_row(buf_next_s[0]);
            end
          end
          ST_WRITE: begin
            if (|valid_s) begin
              overflow <= 1'b1;
            end
            if (wr.wr_ready) begin
              if (row_idx_r == 2'd3) begin
                state_r  <= ST_DONE;
                wr.wr_en <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                // Running address accumulator; wraps modulo 2^ADDR_W.
                row_idx_r  <= row_idx_r + 2'd1;
                wr.wr_addr <= wr.wr_addr + stride_r;
                wr.wr_data <= pack_row(buf_r[row_idx_r + 2'd1]);
              end
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            if (|valid_s) begin
              overflow <= 1'b1;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            wr.wr_en <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_writeback.sv
// Randomized self-checking bench for window_writeback; expected writes come from
// base + r*stride and the bytes each row was given.
module tb_window_writeback;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] row_stride;
  logic signed [7:0] C0 [0:3];
  logic signed [7:0] C1 [0:3];
  logic signed [7:0] C2 [0:3];
  logic signed [7:0] C3 [0:3];
  logic              valid_C0, valid_C1, valid_C2, valid_C3;
  logic              busy, done, overflow;

  window_writeback_if #(.ADDR_W(ADDR_W)) wb ();

  window_writeback #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .C0         (C0),
    .C1         (C1),
    .C2         (C2),
    .C3         (C3),
    .valid_C0   (valid_C0),
    .valid_C1   (valid_C1),
    .valid_C2   (valid_C2),
    .valid_C3   (valid_C3),
    .wr         (wb.master),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  blk [4][4];
  logic [3:0]  sched_real [$];
  logic [3:0]  sched_junk [$];
  logic [15:0] got_a [$];
  logic [31:0] got_d [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r, input bit junk);
    logic [7:0] v;
    for (int e = 0; e < 4; e++) begin
      v = junk ? 8'($urandom) : blk[r][e];
      case (r)
        0: C0[e] = v;
        1: C1[e] = v;
        2: C2[e] = v;
        default: C3[e] = v;
      endcase
    end
  endtask

  task automatic set_valid(input logic [3:0] m);
    valid_C0 = m[0];
    valid_C1 = m[1];
    valid_C2 = m[2];
    valid_C3 = m[3];
  endtask

  task automatic fill_random_block();
    for (int r = 0; r < 4; r++)
      for (int e = 0; e < 4; e++) blk[r][e] = 8'($urandom);
  endtask

  task automatic fill_basic_block();
    for (int r = 0; r < 4; r++)
      for (int e = 0; e < 4; e++) blk[r][e] = 8'(r * 16 + e + 1);
  endtask

  // Random arrival schedule: rows grouped in random order, optional idle cycles,
  // and optional early garbage pulses that the real pulse later overwrites.
  task automatic build_sched(input bit allow_junk);
    int perm [4];
    int i, g, k, tmp;
    logic [3:0] m;
    perm = '{0, 1, 2, 3};
    for (int a = 3; a > 0; a--) begin
      k = int'($urandom_range(0, a));
      tmp = perm[a]; perm[a] = perm[k]; perm[k] = tmp;
    end
    sched_real.delete();
    sched_junk.delete();
    i = 0;
    while (i < 4) begin
      g = int'($urandom_range(1, 4 - i));
      if ($urandom_range(0, 3) == 0) begin
        sched_real.push_back(4'b0000);
        sched_junk.push_back(4'b0000);
      end
      m = 4'b0000;
      for (int b = 0; b < g; b++) m[perm[i + b]] = 1'b1;
      sched_real.push_back(m);
      sched_junk.push_back(4'b0000);
      i += g;
    end
    if (allow_junk)
      for (int j = 1; j < sched_real.size() - 1; j++)
        if ($urandom_range(0, 1) == 1) sched_junk[j - 1] = sched_junk[j - 1] | sched_real[j];
  endtask

  // rmode: 0 = always ready, 1 = 3 stall cycles on row 1, other = random ready.
  task automatic run_block(input logic [15:0] base, input logic [15:0] stride,
                           input int rmode, input bit partial, input bit inject);
    int n, cyc, low_cnt;
    bit held;
    logic [15:0] ha, ea;
    logic [31:0] hd, ed;
    got_a.delete();
    got_d.delete();
    if (partial) begin
      start = 1'b1; base_addr = 16'hDEAD; row_stride = 16'h0BAD;
      step();
      start = 1'b0;
      for (int r = 0; r < 2; r++) begin
        set_row(r, 1'b1);
        set_valid(4'b0001 << r);
        step();
      end
      set_row(2, 1'b1);
      set_valid(4'b0100);
    end
    start = 1'b1; base_addr = base; row_stride = stride;
    step();
    start = 1'b0;
    set_valid(4'b0000);
    check_eq("busy_after_start", 64'(busy), 64'(1'b1));
    check_eq("overflow_cleared_by_start", 64'(overflow), 64'(1'b0));
    for (int j = 0; j < sched_real.size(); j++) begin
      for (int r = 0; r < 4; r++) set_row(r, !sched_real[j][r]);
      set_valid(sched_real[j] | sched_junk[j]);
      step();
      set_valid(4'b0000);
      if (j == sched_real.size() - 1) check_eq("wr_en_after_last_row", 64'(wb.wr_en), 64'(1'b1));
      else check_eq("wr_en_low_collecting", 64'(wb.wr_en), 64'(1'b0));
    end
    n = 0; cyc = 0; low_cnt = 0; held = 1'b0; ha = 16'h0; hd = 32'h0;
    while (n < 4 && cyc < 40) begin
      if (rmode == 0) wb.wr_ready = 1'b1;
      else if (rmode == 1) begin
        if (n == 1 && low_cnt < 3) begin wb.wr_ready = 1'b0; low_cnt++; end
        else wb.wr_ready = 1'b1;
      end else wb.wr_ready = ($urandom_range(0, 2) != 0);
      if (inject && cyc == 0) begin
        set_row(0, 1'b1);
        set_row(3, 1'b1);
        set_valid(4'b1001);
      end
      if (held) begin
        check_eq("hold_wr_en", 64'(wb.wr_en), 64'(1'b1));
        check_eq("hold_wr_addr", 64'(wb.wr_addr), 64'(ha));
        check_eq("hold_wr_data", 64'(wb.wr_data), 64'(hd));
      end
      held = 1'b0;
      if (wb.wr_en && wb.wr_ready) begin
        got_a.push_back(wb.wr_addr);
        got_d.push_back(wb.wr_data);
        n++;
      end else if (wb.wr_en) begin
        held = 1'b1; ha = wb.wr_addr; hd = wb.wr_data;
      end else begin
        check_eq("wr_en_during_write", 64'(wb.wr_en), 64'(1'b1));
      end
      step();
      set_valid(4'b0000);
      cyc++;
    end
    check_eq("accepted_writes", 64'(n), 64'(4));
    if (rmode == 0) check_eq("cycles_back_to_back", 64'(cyc), 64'(4));
    if (rmode == 1) check_eq("cycles_with_stall", 64'(cyc), 64'(7));
    check_eq("done_pulse", 64'(done), 64'(1'b1));
    check_eq("wr_en_in_done", 64'(wb.wr_en), 64'(1'b0));
    check_eq("busy_in_done", 64'(busy), 64'(1'b0));
    check_eq("overflow_after_block", 64'(overflow), 64'(inject));
    for (int r = 0; r < n; r++) begin
      ea = base + 16'(r) * stride;
      ed = {blk[r][0], blk[r][1], blk[r][2], blk[r][3]};
      check_eq($sformatf("wr_addr_row%0d", r), 64'(got_a[r]), 64'(ea));
      check_eq($sformatf("wr_data_row%0d", r), 64'(got_d[r]), 64'(ed));
    end
    wb.wr_ready = 1'b0;
    step();
    check_eq("done_single_cycle", 64'(done), 64'(1'b0));
    check_eq("busy_idle", 64'(busy), 64'(1'b0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 16'h0; row_stride = 16'h0;
    set_valid(4'b0000);
    wb.wr_ready = 1'b0;
    for (int r = 0; r < 4; r++) set_row(r, 1'b1);
    step();
    step();
    check_eq("reset_wr_en", 64'(wb.wr_en), 64'(1'b0));
    check_eq("reset_wr_addr", 64'(wb.wr_addr), 64'(16'h0));
    check_eq("reset_wr_data", 64'(wb.wr_data), 64'(32'h0));
    check_eq("reset_busy", 64'(busy), 64'(1'b0));
    check_eq("reset_done", 64'(done), 64'(1'b0));
    check_eq("reset_overflow", 64'(overflow), 64'(1'b0));
    reset = 1'b0;
    step();

    // Basic block, rows in order.
    fill_basic_block();
    sched_real = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sched_junk = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    run_block(16'h0100, 16'h0010, 0, 1'b0, 1'b0);

    // Out-of-order and simultaneous arrival.
    fill_random_block();
    sched_real = '{4'b0101, 4'b1000, 4'b0010};
    sched_junk = '{4'b0000, 4'b0000, 4'b0000};
    run_block(16'h0400, 16'h0020, 0, 1'b0, 1'b0);

    // Backpressure on row 1.
    fill_basic_block();
    sched_real = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sched_junk = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    run_block(16'h0100, 16'h0010, 1, 1'b0, 1'b0);

    // Address wrap.
    fill_random_block();
    build_sched(1'b0);
    run_block(16'hFFF0, 16'h0008, 0, 1'b0, 1'b0);

    // Overflow in IDLE, restart mid-collect, pulse during WRITE.
    set_row(1, 1'b1);
    set_valid(4'b0010);
    step();
    set_valid(4'b0000);
    check_eq("overflow_idle_pulse", 64'(overflow), 64'(1'b1));
    fill_random_block();
    sched_real = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sched_junk = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    run_block(16'h0800, 16'h0004, 0, 1'b1, 1'b1);

    // Reset while row 2 waits for the memory.
    fill_random_block();
    start = 1'b1; base_addr = 16'h0200; row_stride = 16'h0004;
    step();
    start = 1'b0;
    for (int r = 0; r < 4; r++) set_row(r, 1'b0);
    set_valid(4'b1111);
    step();
    set_valid(4'b0000);
    check_eq("rst_test_wr_en", 64'(wb.wr_en), 64'(1'b1));
    wb.wr_ready = 1'b1;
    step();
    step();
    wb.wr_ready = 1'b0;
    set_row(1, 1'b1);
    set_valid(4'b0010);
    step();
    set_valid(4'b0000);
    check_eq("rst_test_row2_addr", 64'(wb.wr_addr), 64'(16'h0208));
    check_eq("rst_test_row2_data", 64'(wb.wr_data), 64'({blk[2][0], blk[2][1], blk[2][2], blk[2][3]}));
    check_eq("rst_test_overflow_set", 64'(overflow), 64'(1'b1));
    reset = 1'b1;
    step();
    check_eq("mid_reset_wr_en", 64'(wb.wr_en), 64'(1'b0));
    check_eq("mid_reset_busy", 64'(busy), 64'(1'b0));
    check_eq("mid_reset_done", 64'(done), 64'(1'b0));
    check_eq("mid_reset_overflow", 64'(overflow), 64'(1'b0));
    reset = 1'b0;
    step();
    check_eq("post_reset_no_done", 64'(done), 64'(1'b0));
    fill_random_block();
    build_sched(1'b0);
    run_block(16'h1234, 16'h0040, 0, 1'b0, 1'b0);

    // Randomized blocks.
    for (int t = 0; t < 24; t++) begin
      fill_random_block();
      build_sched(1'b1);
      run_block(16'($urandom), 16'($urandom), 2,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/window_writeback.md
Name: window_writeback

Overview:
- Return-path counterpart of the row-window loader. The loader unpacks 32-bit row words into int8 lanes with per-row valid pulses; this block does the reverse.
- Collects a 4x4 int8 result block arriving as four row vectors with per-row valid pulses.
- Packs each row into a 32-bit word and writes the four words to the activation buffer through a valid/ready write port.
- Sits between the systolic array output and the activation SRAM.

Parameters:
- ADDR_W, 16, width of base_addr, row_stride and wr_addr.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  arm for a new block; latches base_addr and row_stride
- base_addr  input  ADDR_W  word address of row 0
- row_stride  input  ADDR_W  word-address increment between rows
- C0  input  4x int8_t [0:3]  row 0 elements
- C1  input  4x int8_t [0:3]  row 1 elements
- C2  input  4x int8_t [0:3]  row 2 elements
- C3  input  4x int8_t [0:3]  row 3 elements
- valid_C0..valid_C3  input  1 each  single-cycle pulse, row r valid
- wr_en  output  1  write request
- wr_addr  output  ADDR_W  write word address
- wr_data  output  32  packed row
- wr_ready  input  1  memory accepts write when wr_en && wr_ready
- busy  output  1  high in COLLECT and WRITE
- done  output  1  one-cycle pulse after 4th write accepted
- overflow  output  1  sticky: row pulse arrived while not collecting

Behaviour:
- Reset values:
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0.
  - Row buffers and capture mask cleared.
- Reset mid-operation: abandons the block; wr_en is low the next cycle; no partial-block completion.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start -> COLLECT; latch base_addr and row_stride; clear mask[3:0] and overflow.
  - Any valid_Cr in IDLE sets overflow; the data is dropped.
- COLLECT:
  - valid_Cr high at an edge captures Cr into buffer r and sets mask[r].
  - Rows may arrive in any order; several pulses may arrive in the same cycle.
  - A repeated pulse for an already-captured row overwrites it (last wins); no error.
  - If the post-edge mask is 4'b1111, transition to WRITE on that same edge. wr_en is high in the cycle immediately after the 4th row's capture edge (1-cycle latency).
  - start in COLLECT restarts: mask cleared, addresses re-latched, overflow cleared; any row pulse on that edge is discarded.
- WRITE:
  - Rows are written in order 0,1,2,3, regardless of arrival order.
  - wr_en is held high.
  - wr_data for row r:
    - [31:24] = Cr[0]
    - [23:16] = Cr[1]
    - [15:8] = Cr[2]
    - [7:0] = Cr[3]
  - wr_addr = base_addr + r*row_stride, modulo 2^ADDR_W; wraps silently. Implemented with a running accumulator, no multiplier.
  - wr_addr and wr_data stay stable while wr_ready=0; no timeout.
  - Each accepted handshake advances r on that edge. Back-to-back acceptance with wr_ready held high gives 4 writes in 4 consecutive cycles.
  - After the handshake for row 3, transition to DONE; wr_en is low in the DONE cycle.
  - valid_Cr in WRITE sets overflow and is dropped; buffers are unchanged.
  - start in WRITE is ignored.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is IDLE, or COLLECT if start is high in the DONE cycle (normal start semantics).
  - valid_Cr in DONE sets overflow.
- busy = (state==COLLECT) || (state==WRITE).
- overflow holds until the next accepted start or reset.

Test Plan:
- Basic block:
  - Stimulus: start with base_addr=0x0100, row_stride=0x0010; pulse valid_C0..valid_C3 on consecutive cycles with C0={01,02,03,04}, C1={11,12,13,14}, C2={21,22,23,24}, C3={31,32,33,34}; wr_ready=1.
  - Response: wr_en rises the cycle after the valid_C3 edge; writes (0x0100,0x01020304), (0x0110,0x11121314), (0x0120,0x21222324), (0x0130,0x31323334) on 4 consecutive cycles; then done=1 for one cycle; busy=0.
- Out-of-order and simultaneous rows:
  - Stimulus: valid_C2 and valid_C0 in the same cycle, then valid_C3, then valid_C1.
  - Response: write order is still rows 0,1,2,3 with the correct addresses and data.
- Backpressure:
  - Stimulus: wr_ready low for 3 cycles on row 1, otherwise high.
  - Response: wr_addr=base+stride and wr_data are held stable for those 3 cycles; exactly 4 accepted writes; done arrives 3 cycles later than in the basic block.
- Address wrap:
  - Stimulus: base_addr=0xFFF0, row_stride=0x0008.
  - Response: wr_addr sequence 0xFFF0, 0xFFF8, 0x0000, 0x0008.
- Overflow and restart:
  - Stimulus: valid_C1 in IDLE -> overflow=1. Then start, capture rows 0-1, start again, then capture all 4 rows -> overflow=0 and only the second block's data is written. Then valid_C0 during WRITE.
  - Response: overflow=1 after the valid_C0 during WRITE; the written data is unchanged.
- Reset mid-write:
  - Stimulus: assert reset during row 2's wait.
  - Response: next cycle wr_en=0, busy=0, done=0, overflow=0; a subsequent full block completes normally.
